video_pattern_src: RTL
======================

Name: video_pattern_src

Overview:
- Synthesizable video stream source that drives the scaler-family input interface: di/de/hs/vs with hs high in blanking and vs high over the active frame.
- Produces frames with runtime-set geometry, blanking and pixel sparsity, and selectable test patterns.
- Used as on-chip stimulus for scaler_v / scaler_h chains and for board bring-up with no sensor attached.

Parameters:
- PIXEL_WIDTH, 8, output pixel width in bits; must be even and at least 8.
- DE_GAP, 0, idle cycles (de_o=0) after every pixel; 0 means a dense line.
- CNT_WIDTH, 16, width of the geometry and blanking inputs and of the counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  run; sampled only in IDLE and at the end of VBLANK.
- line_size  in  CNT_WIDTH  pixels per line minus 1.
- frame_lines  in  CNT_WIDTH  lines per frame minus 1.
- hblank  in  CNT_WIDTH  HBLANK length in cycles; 0 is treated as 1.
- vblank  in  CNT_WIDTH  VBLANK length in cycles; 0 is treated as 1.
- pattern  in  2  0=xy-count, 1=h-ramp, 2=v-ramp, 3=constant.
- const_val  in  PIXEL_WIDTH  pixel value for pattern 3.
- do_o  out  PIXEL_WIDTH  pixel data; valid when de_o=1.
- de_o  out  1  pixel valid.
- hs_o  out  1  1 in blanking, 0 over line active time, including gap cycles.
- vs_o  out  1  1 from the first pixel of line 0 to the end of the last line's active time.
- frame_done_o  out  1  one-cycle pulse on the first VBLANK cycle.

Behaviour:
- All outputs are registered.
- Reset: do_o=0, de_o=0, hs_o=1, vs_o=0, frame_done_o=0, state IDLE, all counters 0.
- rst_n low mid-frame: idle values appear on the edge that samples it. No partial-line flush.
- Config capture: line_size, frame_lines, hblank, vblank, pattern and const_val are latched at frame start. Changes mid-frame have no effect until the next frame.
- IDLE: hs_o=1, vs_o=0, de_o=0.
  - The edge that samples en=1 latches config and enters ACTIVE with x=0, y=0.
  - The first pixel is driven on the next edge.
- ACTIVE: hs_o=0, vs_o=1.
  - Each pixel slot is 1 cycle with de_o=1, then DE_GAP cycles with de_o=0; do_o holds its value.
  - Line length is (line_size+1)*(DE_GAP+1) cycles, gaps after the last pixel included.
  - After the last slot: go to HBLANK, x=0.
- HBLANK: hs_o=1, de_o=0, lasting max(hblank,1) cycles.
  - If y < frame_lines: vs_o stays 1, y increments, return to ACTIVE.
  - If y == frame_lines: vs_o=0 from the first HBLANK cycle; go to VBLANK after HBLANK.
- VBLANK: hs_o=1, vs_o=0, lasting max(vblank,1) cycles. frame_done_o=1 on its first cycle only.
  - At its end, en=1: latch config, enter ACTIVE (back-to-back frames, no IDLE cycle).
  - At its end, en=0: enter IDLE.
- en deasserted mid-frame: the frame completes normally.
- Patterns, with H=PIXEL_WIDTH/2:
  - 0: do_o = {y[H-1:0], (x+1)[H-1:0]}, modulo 2^H.
  - 1: do_o = x[PIXEL_WIDTH-1:0].
  - 2: do_o = y[PIXEL_WIDTH-1:0].
  - 3: do_o = const_val.
- Counters x and y are CNT_WIDTH wide. Pattern truncation wraps silently.
- line_size=0 and frame_lines=0 are legal: 1 pixel per line, 1 line per frame.

Test Plan:
- Dense frame: line_size=3, frame_lines=1, hblank=2, vblank=3, pattern=0, DE_GAP=0, en held 1.
  - do_o with de_o: 0x01,0x02,0x03,0x04, 2 hs_o=1 cycles, then 0x11,0x12,0x13,0x14.
  - vs_o falls with hs_o rising after 0x14. frame_done_o pulses once.
  - The next frame's first pixel appears 3 cycles later; period is 4+2+4+2+3 = 15 cycles.
- Sparse: DE_GAP=1, same geometry.
  - de_o toggles 1,0 over 8 cycles per line while hs_o stays 0.
  - Pixel values match the dense case.
- Degenerate: line_size=0, frame_lines=0, hblank=0, vblank=0, pattern=3, const_val=0xA5.
  - One de_o pulse with 0xA5, then 1 HBLANK and 1 VBLANK cycle; period 3 cycles.
- Config change mid-frame: switch pattern 1 to 2 during line 0.
  - The frame stays an h-ramp (0,1,2,3 per line).
  - The next frame is a v-ramp (0,0,0,0 then 1,1,1,1).
- en dropped during line 0 of a 2-line frame: both lines complete, then IDLE with hs_o=1, vs_o=0, de_o=0.
- rst_n=0 asserted on pixel 2 of line 1:
  - Next edge shows hs_o=1, vs_o=0, de_o=0, do_o=0.
  - After release with en=1, a fresh frame starts at 0x01.

Source files
------------

// File: rtl/video_pattern_src.sv
// Test-pattern video source producing di/de/hs/vs framing for scaler-family inputs.
// Outputs are registered one cycle behind the internal state; no backpressure, config latched per frame.
module video_pattern_src #(
    parameter int PIXEL_WIDTH = 8,
    parameter int DE_GAP      = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [CNT_WIDTH-1:0]   line_size,
    input  logic [CNT_WIDTH-1:0]   frame_lines,
    input  logic [CNT_WIDTH-1:0]   hblank,
    input  logic [CNT_WIDTH-1:0]   vblank,
    input  logic [1:0]             pattern,
    input  logic [PIXEL_WIDTH-1:0] const_val,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   frame_done_o
);
    localparam int H = PIXEL_WIDTH / 2;
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] ZERO     = '0;
    localparam logic [CNT_WIDTH-1:0] GAP_LAST = CNT_WIDTH'(DE_GAP);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   x_q, x_d, y_q, y_d, g_q, g_d, b_q, b_d;
    logic [CNT_WIDTH-1:0]   ls_q, ls_d, fl_q, fl_d;
    logic [CNT_WIDTH-1:0]   hb_last_q, hb_last_d, vb_last_q, vb_last_d;
    logic [1:0]             pat_q, pat_d;
    logic [PIXEL_WIDTH-1:0] cv_q, cv_d;
    logic [PIXEL_WIDTH-1:0] do_q, do_d;
    logic                   de_q, de_d, hs_q, hs_d, vs_q, vs_d, fd_q, fd_d;
    logic                   start;
    logic [H-1:0]           x_inc;
    logic [PIXEL_WIDTH-1:0] pix;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        g_d       = g_q;
        b_d       = b_q;
        ls_d      = ls_q;
        fl_d      = fl_q;
        hb_last_d = hb_last_q;
        vb_last_d = vb_last_q;
        pat_d     = pat_q;
        cv_d      = cv_q;
        do_d      = do_q;
        de_d      = 1'b0;
        hs_d      = 1'b1;
        vs_d      = 1'b0;
        fd_d      = 1'b0;
        start     = 1'b0;

        // Pattern 0 shows x+1 so the very first pixel of a frame is nonzero.
        x_inc = x_q[H-1:0] + H'(1);
        case (pat_q)
            2'd0:    pix = {y_q[H-1:0], x_inc};
            2'd1:    pix = x_q[PIXEL_WIDTH-1:0];
            2'd2:    pix = y_q[PIXEL_WIDTH-1:0];
            default: pix = cv_q;
        endcase

        case (state_q)
            S_IDLE: start = en;
            S_ACTIVE: begin
                hs_d = 1'b0;
                vs_d = 1'b1;
                de_d = (g_q == ZERO);
                if (g_q == ZERO) do_d = pix;
                if (g_q == GAP_LAST) begin
                    g_d = ZERO;
                    if (x_q == ls_q) begin
                        x_d     = ZERO;
                        b_d     = ZERO;
                        state_d = S_HBLANK;
                    end else begin
                        x_d = x_q + ONE;
                    end
                end else begin
                    g_d = g_q + ONE;
                end
            end
            S_HBLANK: begin
                // vs drops at the start of the last line's HBLANK, not at VBLANK.
                vs_d = (y_q != fl_q);
                if (b_q == hb_last_q) begin
                    b_d = ZERO;
                    if (y_q == fl_q) begin
                        state_d = S_VBLANK;
                    end else begin
                        y_d     = y_q + ONE;
                        state_d = S_ACTIVE;
                    end
                end else begin
                    b_d = b_q + ONE;
                end
            end
            S_VBLANK: begin
                fd_d = (b_q == ZERO);
                if (b_q == vb_last_q) begin
                    b_d = ZERO;
                    if (en) start = 1'b1;
                    else    state_d = S_IDLE;
                end else begin
                    b_d = b_q + ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d   = S_ACTIVE;
            x_d       = ZERO;
            y_d       = ZERO;
            g_d       = ZERO;
            b_d       = ZERO;
            ls_d      = line_size;
            fl_d      = frame_lines;
            hb_last_d = (hblank == ZERO) ? ZERO : hblank - ONE;
            vb_last_d = (vblank == ZERO) ? ZERO : vblank - ONE;
            pat_d     = pattern;
            cv_d      = const_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            ls_q      <= '0;
            fl_q      <= '0;
            hb_last_q <= '0;
            vb_last_q <= '0;
            pat_q     <= '0;
            cv_q      <= '0;
            do_q      <= '0;
            de_q      <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            g_q       <= g_d;
            b_q       <= b_d;
            ls_q      <= ls_d;
            fl_q      <= fl_d;
            hb_last_q <= hb_last_d;
            vb_last_q <= vb_last_d;
            pat_q     <= pat_d;
            cv_q      <= cv_d;
            do_q      <= do_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            fd_q      <= fd_d;
        end
    end

    assign do_o         = do_q;
    assign de_o         = de_q;
    assign hs_o         = hs_q;
    assign vs_o         = vs_q;
    assign frame_done_o = fd_q;
endmodule
